wtb_load_ctrl: RTL and testbench

WTB_LOAD_CTRL -- requirements
Module: wtb_load_ctrl

---
 rtl/wtb_load_ctrl.sv | 161 ++++++++++++++++
 tb/tb_wtb_load_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wtb_load_ctrl.sv
// Wavetable load controller: queues program-change requests, issues one load
// at a time to the wavetable loader and tracks completion, retries and timeouts.
module wtb_load_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 1024,
  parameter int MAX_RETRY  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       prog_chg,
  input  logic [6:0] prog_num,
  output logic       wtb_load,
  output logic [4:0] wtb_num,
  input  logic [4:0] wtb_load_num,
  input  logic       wtb_load_done,
  output logic       busy,
  output logic [4:0] cur_wtb,
  output logic       cur_valid,
  output logic       ovf_err,
  output logic       rng_err,
  output logic       tmo_err,
  output logic       mis_err,
  output logic [1:0] dbg_state
);

  // Handshake: a request is taken on any cycle with prog_chg=1 (no back-pressure);
  // the loader sees a one-cycle wtb_load strobe and answers with wtb_load_done,
  // which only counts while the controller is waiting for it.

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_next;

  // Request FIFO with one extra pointer bit to tell full from empty.
  logic [4:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full;
  logic        req_ok, push, pop;
  logic        ovf_next, rng_next;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign req_ok   = prog_chg && (prog_num[6:5] == 2'b00);
  assign push     = req_ok && (!full || pop);
  assign ovf_next = req_ok && full && !pop;
  assign rng_next = prog_chg && (prog_num[6:5] != 2'b00);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= prog_num[4:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  logic [RW-1:0] retry_cnt;
  logic [TW-1:0] wait_cnt;
  logic          retry_inc;
  logic          mis_next, tmo_next, commit;

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    retry_inc  = 1'b0;
    mis_next   = 1'b0;
    tmo_next   = 1'b0;
    commit     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: state_next = WAIT;
      WAIT: begin
        if (wtb_load_done) begin
          if (wtb_load_num == wtb_num) begin
            state_next = DONE;
          end else begin
            mis_next = 1'b1;
            if (retry_cnt < RETRY_MAX) begin
              retry_inc  = 1'b1;
              state_next = ISSUE;
            end else begin
              state_next = IDLE;
            end
          end
        end else if (wait_cnt == TMO_LAST) begin
          // Timeouts are final: the request is dropped without a retry.
          tmo_next   = 1'b1;
          state_next = IDLE;
        end
      end
      DONE: begin
        commit     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wtb_num   <= '0;
      retry_cnt <= '0;
      wait_cnt  <= '0;
      cur_wtb   <= '0;
      cur_valid <= 1'b0;
      ovf_err   <= 1'b0;
      rng_err   <= 1'b0;
      tmo_err   <= 1'b0;
      mis_err   <= 1'b0;
    end else begin
      state   <= state_next;
      ovf_err <= ovf_next;
      rng_err <= rng_next;
      tmo_err <= tmo_next;
      mis_err <= mis_next;
      if (pop) begin
        wtb_num   <= mem[rd_ptr[AW-1:0]];
        retry_cnt <= '0;
      end else if (retry_inc) begin
        retry_cnt <= retry_cnt + RW'(1);
      end
      // Counter restarts on every entry to WAIT, including after a retry.
      if (state_next == WAIT && state != WAIT) begin
        wait_cnt <= '0;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt + TW'(1);
      end
      if (commit) begin
        cur_wtb   <= wtb_num;
        cur_valid <= 1'b1;
      end
    end
  end

  assign wtb_load  = (state == ISSUE);
  assign busy      = (state != IDLE) || !empty;
  assign dbg_state = state;

endmodule

// File: tb/tb_wtb_load_ctrl.sv
// Directed bench for wtb_load_ctrl: nominal load, overflow, range reject,
// mismatch with retry, timeout and reset during WAIT.
module tb_wtb_load_ctrl;

  logic       clk;
  logic       rst_n;
  logic       prog_chg;
  logic [6:0] prog_num;
  logic       wtb_load;
  logic [4:0] wtb_num;
  logic [4:0] wtb_load_num;
  logic       wtb_load_done;
  logic       busy;
  logic [4:0] cur_wtb;
  logic       cur_valid;
  logic       ovf_err, rng_err, tmo_err, mis_err;
  logic [1:0] dbg_state;

  int n_checks;
  int n_errors;

  wtb_load_ctrl #(.FIFO_DEPTH(4), .TIMEOUT(1024), .MAX_RETRY(1)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .prog_chg      (prog_chg),
    .prog_num      (prog_num),
    .wtb_load      (wtb_load),
    .wtb_num       (wtb_num),
    .wtb_load_num  (wtb_load_num),
    .wtb_load_done (wtb_load_done),
    .busy          (busy),
    .cur_wtb       (cur_wtb),
    .cur_valid     (cur_valid),
    .ovf_err       (ovf_err),
    .rng_err       (rng_err),
    .tmo_err       (tmo_err),
    .mis_err       (mis_err),
    .dbg_state     (dbg_state)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_errs_clear(input string tag);
    chk({tag, "_ovf"}, 32'(ovf_err), 32'd0);
    chk({tag, "_rng"}, 32'(rng_err), 32'd0);
    chk({tag, "_tmo"}, 32'(tmo_err), 32'd0);
    chk({tag, "_mis"}, 32'(mis_err), 32'd0);
  endtask

  // Starts in WAIT for load k: completes it, then checks the follow-up issue.
  task automatic serve(input logic [4:0] k, input bit has_next, input logic [4:0] nxt);
    wtb_load_done = 1'b1;
    wtb_load_num  = k;
    tick();
    wtb_load_done = 1'b0;
    chk("serve_done_state", 32'(dbg_state), 32'd3);
    tick();
    chk("serve_cur_wtb", 32'(cur_wtb), 32'(k));
    chk("serve_cur_valid", 32'(cur_valid), 32'd1);
    tick();
    if (has_next) begin
      chk("serve_next_load", 32'(wtb_load), 32'd1);
      chk("serve_next_num", 32'(wtb_num), 32'(nxt));
    end else begin
      chk("serve_idle_busy", 32'(busy), 32'd0);
      chk("serve_idle_load", 32'(wtb_load), 32'd0);
    end
    tick();
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst_n         = 1'b0;
    prog_chg      = 1'b0;
    prog_num      = '0;
    wtb_load_done = 1'b0;
    wtb_load_num  = '0;

    // Reset state.
    tick();
    tick();
    chk("rst_load", 32'(wtb_load), 32'd0);
    chk("rst_num", 32'(wtb_num), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cur_wtb", 32'(cur_wtb), 32'd0);
    chk("rst_cur_valid", 32'(cur_valid), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    chk_errs_clear("rst");
    rst_n = 1'b1;
    tick();

    // Nominal load of program 7, done three cycles after the strobe.
    prog_chg = 1'b1;
    prog_num = 7'd7;
    tick();
    prog_chg = 1'b0;
    chk("nom_busy_queued", 32'(busy), 32'd1);
    chk("nom_no_load_yet", 32'(wtb_load), 32'd0);
    tick();
    chk("nom_load", 32'(wtb_load), 32'd1);
    chk("nom_num", 32'(wtb_num), 32'd7);
    tick();
    chk("nom_load_one_cycle", 32'(wtb_load), 32'd0);
    chk("nom_wait_state", 32'(dbg_state), 32'd2);
    tick();
    tick();
    wtb_load_done = 1'b1;
    wtb_load_num  = 5'd7;
    tick();
    wtb_load_done = 1'b0;
    chk("nom_done_state", 32'(dbg_state), 32'd3);
    chk("nom_cur_valid_pending", 32'(cur_valid), 32'd0);
    tick();
    chk("nom_cur_wtb", 32'(cur_wtb), 32'd7);
    chk("nom_cur_valid", 32'(cur_valid), 32'd1);
    chk("nom_busy_end", 32'(busy), 32'd0);
    tick();

    // Range rejection of program 40.
    prog_chg = 1'b1;
    prog_num = 7'd40;
    tick();
    prog_chg = 1'b0;
    chk("rng_pulse", 32'(rng_err), 32'd1);
    chk("rng_busy", 32'(busy), 32'd0);
    tick();
    chk("rng_pulse_end", 32'(rng_err), 32'd0);
    chk("rng_no_load", 32'(wtb_load), 32'd0);
    tick();
    chk("rng_no_load2", 32'(wtb_load), 32'd0);
    chk("rng_cur_wtb", 32'(cur_wtb), 32'd7);

    // Overflow: six back-to-back requests while the loader stalls.
    for (int i = 1; i <= 6; i++) begin
      prog_chg = 1'b1;
      prog_num = 7'(i);
      tick();
      if (i == 2) begin
        chk("ovf_first_load", 32'(wtb_load), 32'd1);
        chk("ovf_first_num", 32'(wtb_num), 32'd1);
      end
      if (i < 6) chk("ovf_no_err_early", 32'(ovf_err), 32'd0);
    end
    prog_chg = 1'b0;
    chk("ovf_pulse", 32'(ovf_err), 32'd1);
    tick();
    chk("ovf_pulse_end", 32'(ovf_err), 32'd0);
    serve(5'd1, 1'b1, 5'd2);
    serve(5'd2, 1'b1, 5'd3);
    serve(5'd3, 1'b1, 5'd4);
    serve(5'd4, 1'b1, 5'd5);
    serve(5'd5, 1'b0, 5'd0);

    // Mismatch: request 9, loader answers 3 twice.
    prog_chg = 1'b1;
    prog_num = 7'd9;
    tick();
    prog_chg = 1'b0;
    tick();
    chk("mis_load1", 32'(wtb_load), 32'd1);
    chk("mis_num1", 32'(wtb_num), 32'd9);
    tick();
    wtb_load_done = 1'b1;
    wtb_load_num  = 5'd3;
    tick();
    wtb_load_done = 1'b0;
    chk("mis_pulse1", 32'(mis_err), 32'd1);
    chk("mis_load2", 32'(wtb_load), 32'd1);
    chk("mis_num2", 32'(wtb_num), 32'd9);
    tick();
    chk("mis_pulse1_end", 32'(mis_err), 32'd0);
    wtb_load_done = 1'b1;
    wtb_load_num  = 5'd3;
    tick();
    wtb_load_done = 1'b0;
    chk("mis_pulse2", 32'(mis_err), 32'd1);
    chk("mis_idle", 32'(dbg_state), 32'd0);
    chk("mis_busy", 32'(busy), 32'd0);
    chk("mis_no_load3", 32'(wtb_load), 32'd0);
    chk("mis_cur_wtb", 32'(cur_wtb), 32'd5);
    chk("mis_cur_valid", 32'(cur_valid), 32'd1);
    tick();
    chk("mis_no_load4", 32'(wtb_load), 32'd0);

    // Timeout on 5, with 11 queued behind it.
    prog_chg = 1'b1;
    prog_num = 7'd5;
    tick();
    prog_num = 7'd11;
    tick();
    prog_chg = 1'b0;
    chk("tmo_load", 32'(wtb_load), 32'd1);
    chk("tmo_num", 32'(wtb_num), 32'd5);
    tick();
    chk("tmo_wait_entry", 32'(dbg_state), 32'd2);
    for (int i = 0; i < 1023; i++) tick();
    chk("tmo_not_yet", 32'(tmo_err), 32'd0);
    chk("tmo_still_wait", 32'(dbg_state), 32'd2);
    tick();
    chk("tmo_pulse", 32'(tmo_err), 32'd1);
    chk("tmo_idle", 32'(dbg_state), 32'd0);
    tick();
    chk("tmo_pulse_end", 32'(tmo_err), 32'd0);
    chk("tmo_next_load", 32'(wtb_load), 32'd1);
    chk("tmo_next_num", 32'(wtb_num), 32'd11);
    tick();
    serve(5'd11, 1'b0, 5'd0);

    // Reset during WAIT, then a late done.
    prog_chg = 1'b1;
    prog_num = 7'd20;
    tick();
    prog_chg = 1'b0;
    tick();
    chk("rw_load", 32'(wtb_load), 32'd1);
    tick();
    tick();
    chk("rw_in_wait", 32'(dbg_state), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("rw_load0", 32'(wtb_load), 32'd0);
    chk("rw_num0", 32'(wtb_num), 32'd0);
    chk("rw_busy0", 32'(busy), 32'd0);
    chk("rw_cur_wtb0", 32'(cur_wtb), 32'd0);
    chk("rw_cur_valid0", 32'(cur_valid), 32'd0);
    chk("rw_state0", 32'(dbg_state), 32'd0);
    chk_errs_clear("rw");
    tick();
    rst_n = 1'b1;
    wtb_load_done = 1'b1;
    wtb_load_num  = 5'd20;
    tick();
    wtb_load_done = 1'b0;
    chk("rw_late_state", 32'(dbg_state), 32'd0);
    chk("rw_late_busy", 32'(busy), 32'd0);
    tick();
    tick();
    chk("rw_late_cur_wtb", 32'(cur_wtb), 32'd0);
    chk("rw_late_cur_valid", 32'(cur_valid), 32'd0);
    chk("rw_late_load", 32'(wtb_load), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
